csm_divider_seq: RTL and testbench



---
 rtl/csm_divider_seq.sv | 168 ++++++++++++++++
 tb/tb_csm_divider_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/csm_divider_seq.sv
// Iterative unsigned restoring divider built from controlled-subtract-multiplex
// (CSM) rows. Each row is a borrow-ripple subtractor whose borrow-out picks
// either the difference or the unmodified shifted remainder. BITS_PER_CYCLE
// rows are chained per clock; partial remainder and quotient are registered
// between iterations. Operands and results use valid/ready handshakes.
module csm_divider_seq #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  // Parameter legality
  if (WIDTH < 2) begin : g_width_check
    $error("csm_divider_seq: WIDTH must be at least 2");
  end
  if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bpc_check
    $error("csm_divider_seq: BITS_PER_CYCLE must be non-zero and divide WIDTH");
  end

  localparam int unsigned NumIter = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW    = (NumIter > 1) ? $clog2(NumIter) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumIter - 1);

  // FSM encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend, consumed MSB-first by shifting left
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, one guard bit for 2Y-1
  logic [WIDTH-1:0] quo_q, quo_d;       // quotient, bits enter at the LSB
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             zero_q, zero_d;     // current operation has Y == 0
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  // Outputs of the chained CSM rows for the current iteration
  logic [WIDTH:0]   row_rem;
  logic [WIDTH-1:0] row_dvd;
  logic [WIDTH-1:0] row_quo;

  // Chained CSM rows: shift in a dividend bit, ripple-borrow subtract Y, and
  // keep the difference only when no borrow comes out of the top cell.
  always_comb begin
    logic [WIDTH:0] rs;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] ys;
    logic           b;
    row_rem = rem_q;
    row_dvd = dvd_q;
    row_quo = quo_q;
    ys      = {1'b0, dvs_q};
    rs      = '0;
    diff    = '0;
    b       = 1'b0;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      rs      = {row_rem[WIDTH-1:0], row_dvd[WIDTH-1]};
      row_dvd = {row_dvd[WIDTH-2:0], 1'b0};
      b       = 1'b0;
      for (int i = 0; i <= int'(WIDTH); i++) begin
        diff[i] = rs[i] ^ ys[i] ^ b;
        b       = (~rs[i] & ys[i]) | (~(rs[i] ^ ys[i]) & b);
      end
      row_rem = b ? rs : diff;
      row_quo = {row_quo[WIDTH-2:0], ~b};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i && in_ready_o) begin
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          rem_d   = '0;
          quo_d   = '0;
          zero_d  = (divisor_i == '0);
          // A zero divisor takes a single pass through BUSY so its result is
          // registered on the edge after acceptance.
          cnt_d   = (divisor_i == '0) ? LastCnt : '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        rem_d = row_rem;
        dvd_d = row_dvd;
        quo_d = row_quo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          quotient_d  = zero_q ? '1 : row_quo;
          remainder_d = zero_q ? dvd_q : row_rem[WIDTH-1:0];
          div_zero_d  = zero_q;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_valid_o && out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Handshake outputs decode the state register only
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
    quotient_o  = quotient_q;
    remainder_o = remainder_q;
    div_zero_o  = div_zero_q;
  end

endmodule

// File: tb/tb_csm_divider_seq.sv
// Directed and random checks for csm_divider_seq in two configurations:
// WIDTH=8/BPC=1 and WIDTH=16/BPC=4. Expected results come from a simple
// arithmetic model and flow through per-DUT scoreboard queues.
module tb_csm_divider_seq;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, one row per cycle
  logic       rst_n8, iv8, ir8, ov8, or8, dz8;
  logic [7:0] x8, y8, q8, r8;
  // 16-bit, four rows per cycle
  logic        rst_n16, iv16, ir16, ov16, or16, dz16;
  logic [15:0] x16, y16, q16, r16;

  csm_divider_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n8),
    .in_valid_i  (iv8),
    .in_ready_o  (ir8),
    .dividend_i  (x8),
    .divisor_i   (y8),
    .out_valid_o (ov8),
    .out_ready_i (or8),
    .quotient_o  (q8),
    .remainder_o (r8),
    .div_zero_o  (dz8)
  );

  csm_divider_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk_i       (clk),
    .rst_ni      (rst_n16),
    .in_valid_i  (iv16),
    .in_ready_o  (ir16),
    .dividend_i  (x16),
    .divisor_i   (y16),
    .out_valid_o (ov16),
    .out_ready_i (or16),
    .quotient_o  (q16),
    .remainder_o (r16),
    .div_zero_o  (dz16)
  );

  exp_t sb8[$];
  exp_t sb16[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int w);
    exp_t e;
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    if (y == 16'd0) begin
      e.q  = mask;
      e.r  = x;
      e.dz = 1'b1;
    end else begin
      e.q  = x / y;
      e.r  = x % y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge with the 8-bit DUT idle. hold > 0 keeps
  // out_ready low that many cycles after the result appears.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input int lat, input int hold);
    exp_t e;
    int   cyc;
    check("ready8_idle", {31'd0, ir8}, 32'd1);
    x8  = x;
    y8  = y;
    iv8 = 1'b1;
    or8 = (hold == 0);
    sb8.push_back(model({8'd0, x}, {8'd0, y}, 8));
    @(negedge clk);
    iv8 = 1'b0;
    x8  = 8'($urandom);
    y8  = 8'($urandom);
    cyc = 0;
    while (!ov8 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency8", cyc, lat);
    e = sb8.pop_front();
    check("quot8", {24'd0, q8}, {16'd0, e.q});
    check("rem8", {24'd0, r8}, {16'd0, e.r});
    check("dz8", {31'd0, dz8}, {31'd0, e.dz});
    for (int h = 0; h < hold; h++) begin
      iv8 = h[0];
      x8  = 8'($urandom);
      y8  = 8'($urandom);
      @(negedge clk);
      check("bp_valid8", {31'd0, ov8}, 32'd1);
      check("bp_ready8", {31'd0, ir8}, 32'd0);
      check("bp_quot8", {24'd0, q8}, {16'd0, e.q});
      check("bp_rem8", {24'd0, r8}, {16'd0, e.r});
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    check("post_valid8", {31'd0, ov8}, 32'd0);
    check("post_ready8", {31'd0, ir8}, 32'd1);
  endtask

  // Lean variant for the 16-bit sweep; out_ready held high.
  task automatic run16(input logic [15:0] x, input logic [15:0] y, input int lat);
    exp_t e;
    int   cyc;
    x16  = x;
    y16  = y;
    iv16 = 1'b1;
    sb16.push_back(model(x, y, 16));
    @(negedge clk);
    iv16 = 1'b0;
    x16  = 16'($urandom);
    y16  = 16'($urandom);
    cyc  = 0;
    while (!ov16 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency16", cyc, lat);
    e = sb16.pop_front();
    check("quot16", {16'd0, q16}, {16'd0, e.q});
    check("rem16", {16'd0, r16}, {16'd0, e.r});
    check("dz16", {31'd0, dz16}, {31'd0, e.dz});
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int seen;
    logic [15:0] rx, ry;
    rst_n8  = 1'b0;
    rst_n16 = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; x8 = '0; y8 = '0;
    iv16 = 1'b0; or16 = 1'b1; x16 = '0; y16 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready8", {31'd0, ir8}, 32'd1);
    check("rst_valid8", {31'd0, ov8}, 32'd0);
    check("rst_quot8", {24'd0, q8}, 32'd0);
    check("rst_rem8", {24'd0, r8}, 32'd0);
    check("rst_dz8", {31'd0, dz8}, 32'd0);
    check("rst_ready16", {31'd0, ir16}, 32'd1);
    rst_n8  = 1'b1;
    rst_n16 = 1'b1;
    @(negedge clk);

    // Basic and boundary divisions
    run8(8'd100, 8'd7, 8, 0);
    run8(8'd255, 8'd1, 8, 0);
    run8(8'd3, 8'd200, 8, 0);
    run8(8'd200, 8'd200, 8, 0);
    // Divide by zero, then a normal result must clear div_zero
    run8(8'd5, 8'd0, 1, 0);
    run8(8'd9, 8'd3, 8, 0);
    // Backpressure with ignored in_valid pulses
    run8(8'd77, 8'd5, 8, 5);

    // Asynchronous reset during BUSY iteration 4
    x8  = 8'd100;
    y8  = 8'd7;
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n8 = 1'b0;
    #1;
    check("arst_valid8", {31'd0, ov8}, 32'd0);
    check("arst_ready8", {31'd0, ir8}, 32'd1);
    check("arst_quot8", {24'd0, q8}, 32'd0);
    check("arst_rem8", {24'd0, r8}, 32'd0);
    check("arst_dz8", {31'd0, dz8}, 32'd0);
    @(negedge clk);
    rst_n8 = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    check("arst_flushed8", seen, 0);
    run8(8'd100, 8'd7, 8, 0);

    // 16-bit, four rows per cycle
    run16(16'd65535, 16'd255, 4);
    for (int n = 0; n < 10000; n++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 15))
                                       : 16'($urandom_range(0, 65535));
      run16(rx, ry, (ry == 16'd0) ? 1 : 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
